// File: rtl/switch_alloc_ctrl_4rad.sv
// switch_alloc_ctrl_4rad
// Packet-level output allocator for a 4-radix butterfly switch node.
// Each output port has a small IDLE/LOCKED FSM. While IDLE it picks one
// requesting input. While LOCKED it follows that input's flits until the tail.
// The registered sel/shift/busy outputs drive the node's mux/shifter datapath.
// That datapath registers its input flits once, so these outputs line up with it.
module switch_alloc_ctrl_4rad #(
  parameter bit RR_EN = 1'b1,
  localparam int PORTS = 4,
  localparam int RW = $clog2(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0][3:0]       in_ch_hdr_msn,
  output logic [PORTS-1:0]            in_gnt,
  output logic [PORTS-1:0][PORTS-1:0] sel,
  output logic [PORTS-1:0]            shift,
  output logic [PORTS-1:0]            busy,
  output logic                        proto_err
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [1:0] FT_IDLE = 2'b00;
  localparam logic [1:0] FT_HDR  = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  state_t                        state_q  [PORTS];
  state_t                        state_d  [PORTS];
  logic   [RW-1:0]               owner_q  [PORTS];
  logic   [RW-1:0]               owner_d  [PORTS];
  logic   [RW-1:0]               rr_q     [PORTS];
  logic   [RW-1:0]               rr_d     [PORTS];

  logic   [1:0]                  ftype    [PORTS];
  logic   [RW-1:0]               route    [PORTS];
  logic   [PORTS-1:0]            owns;
  logic   [PORTS-1:0]            win_vld;
  logic   [RW-1:0]               win_idx  [PORTS];

  logic   [PORTS-1:0][PORTS-1:0] sel_d;
  logic   [PORTS-1:0]            shift_d;
  logic   [PORTS-1:0]            busy_d;
  logic                          err_d;

  // Split each input nibble into its flit type and requested output port
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      ftype[i] = in_ch_hdr_msn[i][3:2];
      route[i] = in_ch_hdr_msn[i][RW-1:0];
    end
  end

  // An input owns an output when some locked output names it as owner
  always_comb begin
    owns = '0;
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        if (state_q[o] == ST_LOCKED && owner_q[o] == RW'(i)) begin
          owns[i] = 1'b1;
        end
      end
    end
  end

  // Per-output arbitration among free inputs presenting a header for this output
  always_comb begin
    logic [RW-1:0] start;
    logic [RW-1:0] idx;
    start   = '0;
    idx     = '0;
    win_vld = '0;
    for (int o = 0; o < PORTS; o++) begin
      win_idx[o] = '0;
      start      = RR_EN ? rr_q[o] : '0;
      for (int k = 0; k < PORTS; k++) begin
        idx = start + RW'(k);
        if (state_q[o] == ST_IDLE && !win_vld[o] &&
            ftype[idx] == FT_HDR && route[idx] == RW'(o) && !owns[idx]) begin
          win_vld[o] = 1'b1;
          win_idx[o] = idx;
        end
      end
    end
  end

  // Fold the per-output winners into the per-input accept strobe
  always_comb begin
    in_gnt = '0;
    for (int o = 0; o < PORTS; o++) begin
      if (win_vld[o]) begin
        in_gnt[win_idx[o]] = 1'b1;
      end
    end
  end

  // Next-state for each output FSM, plus the datapath controls it produces
  always_comb begin
    sel_d   = '0;
    shift_d = '0;
    busy_d  = '0;
    for (int o = 0; o < PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      rr_d[o]    = rr_q[o];
      case (state_q[o])
        ST_IDLE: begin
          if (win_vld[o]) begin
            state_d[o]             = ST_LOCKED;
            owner_d[o]             = win_idx[o];
            rr_d[o]                = win_idx[o] + 1'b1;
            sel_d[o][win_idx[o]]   = 1'b1;
            shift_d[o]             = 1'b1;
            busy_d[o]              = 1'b1;
          end
        end
        ST_LOCKED: begin
          sel_d[o][owner_q[o]] = 1'b1;
          busy_d[o]            = 1'b1;
          if (ftype[owner_q[o]] == FT_TAIL) begin
            state_d[o] = ST_IDLE;
          end
        end
        default: begin
          state_d[o] = ST_IDLE;
        end
      endcase
    end
  end

  // Framing check: stray body/tail, or a header from an input that already owns an output
  always_comb begin
    err_d = proto_err;
    for (int i = 0; i < PORTS; i++) begin
      if (((ftype[i] == FT_BODY || ftype[i] == FT_TAIL) && !owns[i]) ||
          (ftype[i] == FT_HDR && owns[i])) begin
        err_d = 1'b1;
      end
    end
  end

  // Output FSM state, owner and round-robin pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= ST_IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
      end
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= state_d[o];
        owner_q[o] <= owner_d[o];
        rr_q[o]    <= rr_d[o];
      end
    end
  end

  // Registered datapath controls and the sticky framing-error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel       <= '0;
      shift     <= '0;
      busy      <= '0;
      proto_err <= 1'b0;
    end else begin
      sel       <= sel_d;
      shift     <= shift_d;
      busy      <= busy_d;
      proto_err <= err_d;
    end
  end

endmodule

// File: tb/tb_switch_alloc_ctrl_4rad.sv
// Directed testbench for switch_alloc_ctrl_4rad (round-robin build)
module tb_switch_alloc_ctrl_4rad;

  logic            clk;
  logic            rst;
  logic [3:0][3:0] in_ch;
  logic [3:0]      in_gnt;
  logic [3:0][3:0] sel;
  logic [3:0]      shift;
  logic [3:0]      busy;
  logic            proto_err;

  int checks = 0;
  int errors = 0;

  switch_alloc_ctrl_4rad #(.RR_EN(1'b1)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_ch_hdr_msn (in_ch),
    .in_gnt        (in_gnt),
    .sel           (sel),
    .shift         (shift),
    .busy          (busy),
    .proto_err     (proto_err)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset across one edge with idle inputs
  task automatic do_reset();
    in_ch = '0;
    rst   = 1'b1;
    cycle();
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    in_ch = '0;
    rst   = 1'b0;
    #2;
    rst   = 1'b1;
    #1;
    checks++; if (sel !== 16'h0000) begin errors++; $display("[TB] FAIL reset_sel: got %h expected %h", sel, 16'h0000); end
    checks++; if (busy !== 4'b0000) begin errors++; $display("[TB] FAIL reset_busy: got %b expected %b", busy, 4'b0000); end
    checks++; if (shift !== 4'b0000) begin errors++; $display("[TB] FAIL reset_shift: got %b expected %b", shift, 4'b0000); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected %b", proto_err, 1'b0); end
    checks++; if (in_gnt !== 4'b0000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected %b", in_gnt, 4'b0000); end
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    do_reset();
    in_ch[2] = 4'b0111;
    #1;
    checks++; if (in_gnt !== 4'b0100) begin errors++; $display("[TB] FAIL single_gnt: got %b expected %b", in_gnt, 4'b0100); end
    cycle();
    checks++; if (sel[3] !== 4'b0100) begin errors++; $display("[TB] FAIL single_sel_hdr: got %b expected %b", sel[3], 4'b0100); end
    checks++; if (shift !== 4'b1000) begin errors++; $display("[TB] FAIL single_shift_hdr: got %b expected %b", shift, 4'b1000); end
    checks++; if (busy !== 4'b1000) begin errors++; $display("[TB] FAIL single_busy_hdr: got %b expected %b", busy, 4'b1000); end
    in_ch[2] = 4'b1000;
    #1;
    checks++; if (in_gnt !== 4'b0000) begin errors++; $display("[TB] FAIL single_gnt_body: got %b expected %b", in_gnt, 4'b0000); end
    cycle();
    checks++; if (sel[3] !== 4'b0100 || shift !== 4'b0000) begin errors++; $display("[TB] FAIL single_body1: got sel %b shift %b expected sel 0100 shift 0000", sel[3], shift); end
    in_ch[2] = 4'b1011;
    cycle();
    checks++; if (sel[3] !== 4'b0100 || shift !== 4'b0000) begin errors++; $display("[TB] FAIL single_body2: got sel %b shift %b expected sel 0100 shift 0000", sel[3], shift); end
    in_ch[2] = 4'b1100;
    cycle();
    checks++; if (sel[3] !== 4'b0100 || shift !== 4'b0000 || busy !== 4'b1000) begin errors++; $display("[TB] FAIL single_tail: got sel %b shift %b busy %b expected sel 0100 shift 0000 busy 1000", sel[3], shift, busy); end
    in_ch[2] = 4'b0000;
    cycle();
    checks++; if (sel !== 16'h0000 || busy !== 4'b0000) begin errors++; $display("[TB] FAIL single_release: got sel %h busy %b expected sel 0000 busy 0000", sel, busy); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL single_err: got %b expected %b", proto_err, 1'b0); end
  endtask

  task automatic test_contention();
    do_reset();
    in_ch[0] = 4'b0100;
    in_ch[1] = 4'b0100;
    #1;
    checks++; if (in_gnt !== 4'b0001) begin errors++; $display("[TB] FAIL cont_gnt_first: got %b expected %b", in_gnt, 4'b0001); end
    cycle();
    checks++; if (sel[0] !== 4'b0001) begin errors++; $display("[TB] FAIL cont_sel_first: got %b expected %b", sel[0], 4'b0001); end
    in_ch[0] = 4'b1100;
    #1;
    checks++; if (in_gnt !== 4'b0000) begin errors++; $display("[TB] FAIL cont_gnt_held: got %b expected %b", in_gnt, 4'b0000); end
    cycle();
    checks++; if (sel[0] !== 4'b0001) begin errors++; $display("[TB] FAIL cont_sel_tail: got %b expected %b", sel[0], 4'b0001); end
    in_ch[0] = 4'b0000;
    #1;
    checks++; if (in_gnt !== 4'b0010) begin errors++; $display("[TB] FAIL cont_gnt_second: got %b expected %b", in_gnt, 4'b0010); end
    cycle();
    checks++; if (sel[0] !== 4'b0010 || shift[0] !== 1'b1) begin errors++; $display("[TB] FAIL cont_sel_second: got sel %b shift %b expected sel 0010 shift 1", sel[0], shift[0]); end
    in_ch[0] = 4'b0100;
    in_ch[1] = 4'b1100;
    #1;
    checks++; if (in_gnt !== 4'b0000) begin errors++; $display("[TB] FAIL cont_gnt_locked: got %b expected %b", in_gnt, 4'b0000); end
    cycle();
    in_ch[1] = 4'b0100;
    #1;
    checks++; if (in_gnt !== 4'b0001) begin errors++; $display("[TB] FAIL cont_gnt_wrap: got %b expected %b", in_gnt, 4'b0001); end
    cycle();
    checks++; if (sel[0] !== 4'b0001 || shift[0] !== 1'b1) begin errors++; $display("[TB] FAIL cont_sel_wrap: got sel %b shift %b expected sel 0001 shift 1", sel[0], shift[0]); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL cont_err: got %b expected %b", proto_err, 1'b0); end
  endtask

  task automatic test_parallel();
    do_reset();
    in_ch[0] = 4'b0101;
    in_ch[1] = 4'b0100;
    in_ch[2] = 4'b0111;
    in_ch[3] = 4'b0110;
    #1;
    checks++; if (in_gnt !== 4'b1111) begin errors++; $display("[TB] FAIL par_gnt: got %b expected %b", in_gnt, 4'b1111); end
    cycle();
    checks++; if (sel !== 16'b0100_1000_0001_0010) begin errors++; $display("[TB] FAIL par_sel: got %b expected %b", sel, 16'b0100_1000_0001_0010); end
    checks++; if (shift !== 4'b1111 || busy !== 4'b1111) begin errors++; $display("[TB] FAIL par_shift_busy: got shift %b busy %b expected 1111 1111", shift, busy); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_ch[1] = 4'b0110;
    cycle();
    in_ch[1] = 4'b1110;
    cycle();
    checks++; if (sel[2] !== 4'b0010 || shift[2] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_tail: got sel %b shift %b expected sel 0010 shift 0", sel[2], shift[2]); end
    in_ch[1] = 4'b0000;
    in_ch[3] = 4'b0110;
    #1;
    checks++; if (in_gnt !== 4'b1000) begin errors++; $display("[TB] FAIL b2b_gnt: got %b expected %b", in_gnt, 4'b1000); end
    cycle();
    checks++; if (sel[2] !== 4'b1000 || shift[2] !== 1'b1 || busy[2] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_sel: got sel %b shift %b busy %b expected sel 1000 shift 1 busy 1", sel[2], shift[2], busy[2]); end
  endtask

  task automatic test_proto_err();
    do_reset();
    in_ch[0] = 4'b1000;
    cycle();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL err_stray_body: got %b expected %b", proto_err, 1'b1); end
    checks++; if (sel !== 16'h0000 || busy !== 4'b0000) begin errors++; $display("[TB] FAIL err_stray_nochange: got sel %h busy %b expected sel 0000 busy 0000", sel, busy); end
    in_ch[0] = 4'b0000;
    cycle();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL err_sticky: got %b expected %b", proto_err, 1'b1); end
    do_reset();
    checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL err_cleared: got %b expected %b", proto_err, 1'b0); end
    in_ch[2] = 4'b0101;
    cycle();
    #1;
    checks++; if (in_gnt !== 4'b0000) begin errors++; $display("[TB] FAIL err_rehdr_gnt: got %b expected %b", in_gnt, 4'b0000); end
    cycle();
    checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL err_rehdr: got %b expected %b", proto_err, 1'b1); end
    checks++; if (sel[1] !== 4'b0100 || shift[1] !== 1'b0) begin errors++; $display("[TB] FAIL err_rehdr_hold: got sel %b shift %b expected sel 0100 shift 0", sel[1], shift[1]); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    in_ch[0] = 4'b0101;
    cycle();
    checks++; if (sel[1] !== 4'b0001) begin errors++; $display("[TB] FAIL rmid_sel_pre: got %b expected %b", sel[1], 4'b0001); end
    in_ch[0] = 4'b1000;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (sel !== 16'h0000 || busy !== 4'b0000 || shift !== 4'b0000) begin errors++; $display("[TB] FAIL rmid_async: got sel %h busy %b shift %b expected all zero", sel, busy, shift); end
    in_ch[0] = 4'b0000;
    cycle();
    rst = 1'b0;
    in_ch[3] = 4'b0101;
    #1;
    checks++; if (in_gnt !== 4'b1000) begin errors++; $display("[TB] FAIL rmid_gnt: got %b expected %b", in_gnt, 4'b1000); end
    cycle();
    checks++; if (sel[1] !== 4'b1000 || shift[1] !== 1'b1) begin errors++; $display("[TB] FAIL rmid_sel_post: got sel %b shift %b expected sel 1000 shift 1", sel[1], shift[1]); end
  endtask

  // Run every scenario in order, then report
  initial begin
    rst   = 1'b0;
    in_ch = '0;
    test_reset();
    test_single_packet();
    test_contention();
    test_parallel();
    test_back_to_back();
    test_proto_err();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_alloc_ctrl_4rad.md
# switch_alloc_ctrl_4rad

Packet-level output allocator for the 4-radix butterfly switch node. Each cycle it takes the type/route nibble of every input channel and grants each output port to at most one input, holding that grant from header flit to tail flit. It produces the per-output one-hot mux selects and route-shift enables that drive the node's mux/shifter datapath. It also returns a per-input accept strobe so upstream stages hold a blocked header.

## Interface
- PORTS, 4 (localparam), switch radix; route field is $clog2(PORTS) = 2 bits.
- RR_EN, 1, 1 = round-robin arbitration per output; 0 = fixed priority, lowest input index wins.

- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_ch_hdr_msn  input  [PORTS-1:0][3:0]  per input: [3:2] flit type, [1:0] requested output port; sampled only when type is header.
- in_gnt  output  [PORTS-1:0]  combinational; 1 in the cycle a header on input i wins an output.
- sel  output  [PORTS-1:0][PORTS-1:0]  registered; sel[o] is one-hot of the owning input, or 0 when output o is idle.
- shift  output  [PORTS-1:0]  registered; shift[o]=1 only in the cycle sel[o] carries a header flit.
- busy  output  [PORTS-1:0]  registered; output o is locked to an input.
- proto_err  output  1  registered, sticky; framing violation seen.

## Operation
- Flit type encoding: 2'b00 idle, 2'b01 header, 2'b10 body, 2'b11 tail. Minimum packet is header+tail.
- Per-output FSM, states IDLE and LOCKED, plus owner[o] (2 b) and rr[o] (2 b).
- IDLE: the candidates are inputs presenting a header with route == o that do not already own an output.
  - RR_EN=1: search starts at rr[o] and wraps modulo 4. RR_EN=0: search starts at input 0.
  - On a winner i: in_gnt[i]=1, owner[o]<=i, go to LOCKED, rr[o]<=(i+1)%4.
- LOCKED: follow owner's flits. Body keeps the lock. Tail returns the FSM to IDLE at the next edge. Idle flits from the owner are bubbles and keep the lock.
- The output that sees a tail is not arbitrated in that same cycle. It becomes arbitrable in the following cycle.
- Several outputs may grant in the same cycle, one each to different inputs. One input can hold at most one output.
- A losing header keeps in_gnt=0. Upstream must present the same header every cycle until in_gnt=1.
- proto_err is set and stays set until reset on any of these:
  - body or tail on an input that owns no output;
  - header on an input that already owns an output.
- The offending flit is ignored: no state change other than proto_err.

## Timing
- Latency 1 cycle: a header granted at edge t appears as sel[o]=onehot(i), shift[o]=1, busy[o]=1 after edge t+1.
- The datapath aligns by registering its input flits once.
- Body/tail seen in cycle k gives sel[o] unchanged after edge k+1, shift[o]=0.
- The tail is driven after edge k+1. From edge k+2, sel[o]=0 and busy[o]=0, unless a new grant was made in cycle k+1.
- Back-to-back: tail in cycle k and next header in cycle k+1 give a gap-free sel.
- in_gnt is combinational from in_ch_hdr_msn, busy, owner and rr. It carries no register and adds no latency.
- Reset (asynchronous, any time, including mid-packet): sel=0, shift=0, busy=0, proto_err=0, owner=0, rr=0, all FSMs IDLE.
  - in_gnt settles to its combinational value with all outputs IDLE.
  - Partial packets are dropped. Upstream restarts with a header.

## Test plan
- Single packet: input 2 sends header route 3 (nibble 4'b0111), then 2 body (4'b10xx), then tail (4'b11xx).
  - in_gnt[2]=1 in the header cycle.
  - Next cycle: sel[3]=4'b0100, shift[3]=1. Then 3 cycles sel[3]=4'b0100, shift[3]=0. Then sel[3]=0, busy[3]=0.
- Contention, RR_EN=1, after reset: inputs 0 and 1 both send a header to output 0.
  - Input 0 is granted and input 1 is held.
  - After input 0's tail, input 1 is granted in the cycle following the tail. rr[0] advances to 2.
  - Repeat with both contending and rr=2: input 0 still wins, because the wrap search from 2 hits 0 first.
- Parallel: headers 0→1, 1→0, 2→3, 3→2 in the same cycle give all four in_gnt=1.
  - Next cycle: sel = {4'b0100, 4'b1000, 4'b0001, 4'b0010} for outputs 3..0.
- Back-to-back: input 1 sends tail to output 2 in cycle k, and input 3 sends a header to 2 in cycle k+1.
  - sel[2] goes 4'b0010 (tail) and then 4'b1000 with shift[2]=1, with no zero cycle.
- Protocol errors: body on an unowned input 0 sets proto_err=1 next cycle and changes no sel. A second header from an owning input also sets it.
  - proto_err stays 1 until rst.
- Reset mid-packet: assert rst while sel[1]=4'b0001.
  - Immediately sel=0, busy=0, shift=0.
  - After release, a new header on input 3 to output 1 wins, since rr=0 and it is the only requester.
